// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_addsub_bit.sv
// One-bit full adder with its carry flop; the carry is preset on load and
// advanced on each enabled cycle.
module serial_addsub_bit (
   input  logic CLK,
   input  logic RN,
   input  logic a,
   input  logic b,
   input  logic load,
   input  logic preset,
   input  logic en,
   output logic sum,
   output logic carry,
   output logic carry_in
);

   logic c_q;

   assign carry_in = c_q;
   assign sum      = a ^ b ^ c_q;
   assign carry    = (a & b) | (a & c_q) | (b & c_q);

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN)       c_q <= 1'b0;
      else if (load) c_q <= preset;
      else if (en)   c_q <= carry;
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder step per cycle, LSB first, with a
// valid/ready handshake on both the request and the result side.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_q;
   logic [CW-1:0]    cnt;
   logic             cout_q, ovf_q;
   logic             accept, busy, last;
   logic             bit_sum, bit_carry, bit_cin;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign busy      = (state == SHIFT);
   assign last      = (cnt == CW'(WIDTH - 1));
   assign result    = res_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: invert b here, the +1 comes from the carry preset.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_q  <= '0;
         cnt    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a_sr <= a;
         b_sr <= sub ? ~b : b;
         cnt  <= '0;
      end else if (busy) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         res_q <= {bit_sum, res_q[WIDTH-1:1]};
         if (last) begin
            cout_q <= bit_carry;
            ovf_q  <= bit_cin ^ bit_carry;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   serial_addsub_bit u_bit (
      .CLK      (CLK),
      .RN       (RN),
      .a        (a_sr[0]),
      .b        (b_sr[0]),
      .load     (accept),
      .preset   (sub),
      .en       (busy),
      .sum      (bit_sum),
      .carry    (bit_carry),
      .carry_in (bit_cin)
   );

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (WIDTH=8): directed cases, backpressure, throughput,
// mid-operation reset and randomized traffic against an arithmetic model.
module tb_serial_addsub;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RN;
   logic         in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, result;

   int total = 0;
   int bad   = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RN        (RN),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: signed/unsigned integer arithmetic on the operands.
   task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                            output logic [W-1:0] rr, output logic rc, output logic ro);
      int ua, ub, sa, sb, us, ss;
      ua = int'(ra);
      ub = int'(rb);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      if (rs) begin
         us = ua - ub;
         ss = sa - sb;
         rc = (ua >= ub);
      end else begin
         us = ua + ub;
         ss = sa + sb;
         rc = (us > 255);
      end
      rr = W'(us & 255);
      ro = (ss > 127) || (ss < -128);
   endtask

   // Issues one request from IDLE, holds the result for 'stall' extra cycles,
   // then releases it; returns outputs at first and last DONE cycle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input int stall, output int lat,
                         output logic [W-1:0] r1, output logic c1, output logic o1,
                         output logic [W-1:0] r2, output logic c2, output logic o2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = ta; b = tb; sub = ts;
      lat = 0;
      do begin
         @(posedge CLK);
         @(negedge CLK);
         lat++;
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      end while (!out_valid && lat < 40);
      r1 = result; c1 = cout; o1 = ovf;
      for (int i = 0; i < stall; i++) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      r2 = result; c2 = cout; o2 = ovf;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      RN = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      #23;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (result !== 8'h00)   begin bad++; $display("FAIL reset_result got=%h want=00", result); end
      total++; if (cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
      total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
      @(negedge CLK);
      RN = 1'b1;
      @(negedge CLK);
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [5] = '{8'h3C, 8'h7F, 8'hFF, 8'h05, 8'h80};
      logic [W-1:0] tb [5] = '{8'h05, 8'h01, 8'h01, 8'h07, 8'h01};
      logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] er [5] = '{8'h41, 8'h80, 8'h00, 8'hFE, 8'h7F};
      logic         ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic         eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int lat;
      logic [W-1:0] r1, r2;
      logic c1, o1, c2, o2;
      for (int k = 0; k < 5; k++) begin
         run_op(ta[k], tb[k], ts[k], 0, lat, r1, c1, o1, r2, c2, o2);
         total++; if (lat != W + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, W + 1); end
         total++; if (r1 !== er[k]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", k, r1, er[k]); end
         total++; if (c1 !== ec[k]) begin bad++; $display("FAIL dir%0d_cout got=%b want=%b", k, c1, ec[k]); end
         total++; if (o1 !== eo[k]) begin bad++; $display("FAIL dir%0d_ovf got=%b want=%b", k, o1, eo[k]); end
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      int lat;
      logic [W-1:0] r1, r2, er;
      logic c1, o1, c2, o2, ec, eo;
      in_valid = 1'b1; a = 8'h55; b = 8'h22; sub = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      RN = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
         bad++; $display("FAIL midreset_outputs got=%b/%h/%b/%b want=0/00/0/0", out_valid, result, cout, ovf);
      end
      @(negedge CLK);
      RN = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL midreset_ghost_result got=%0d want=0", seen); end
      ref_model(8'hC3, 8'h4A, 1'b1, er, ec, eo);
      run_op(8'hC3, 8'h4A, 1'b1, 0, lat, r1, c1, o1, r2, c2, o2);
      total++; if (r1 !== er || c1 !== ec || o1 !== eo) begin
         bad++; $display("FAIL midreset_next_op got=%h/%b/%b want=%h/%b/%b", r1, c1, o1, er, ec, eo);
      end
   endtask

   task automatic test_backpressure;
      int n;
      logic [W-1:0] held;
      logic [W-1:0] er;
      logic ec, eo;
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_reach_done got=%b want=1", out_valid); end
      held = result;
      total++; if (held !== 8'h46) begin bad++; $display("FAIL bp_result got=%h want=46", held); end
      in_valid = 1'b1; a = 8'h09; b = 8'h03; sub = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) begin
            bad++; $display("FAIL bp_hold%0d got=%b/%b/%h want=1/0/%h", i, out_valid, in_ready, result, held);
         end
      end
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=%b/%b want=0/1", out_valid, in_ready);
      end
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b want=0", in_ready); end
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end
      ref_model(8'h09, 8'h03, 1'b1, er, ec, eo);
      total++; if (result !== er || cout !== ec || ovf !== eo) begin
         bad++; $display("FAIL bp_next_result got=%h/%b/%b want=%h/%b/%b", result, cout, ovf, er, ec, eo);
      end
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int n, acc2, done1;
      logic [W-1:0] er;
      logic ec, eo;
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'hA5; b = 8'h5A; sub = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      a = 8'h10; b = 8'h20; sub = 1'b1;
      n = 0; acc2 = 0; done1 = 0;
      while (acc2 == 0 && n < 40) begin
         if (out_valid) begin
            done1 = 1;
            total++; if (result !== 8'hFF || cout !== 1'b0 || ovf !== 1'b0) begin
               bad++; $display("FAIL b2b_first got=%h/%b/%b want=ff/0/0", result, cout, ovf);
            end
         end
         if (in_ready && done1 != 0) acc2 = n + 1;
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end
      in_valid = 1'b0;
      total++; if (acc2 != W + 2) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", acc2, W + 2); end
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end
      ref_model(8'h10, 8'h20, 1'b1, er, ec, eo);
      total++; if (result !== er || cout !== ec || ovf !== eo) begin
         bad++; $display("FAIL b2b_second got=%h/%b/%b want=%h/%b/%b", result, cout, ovf, er, ec, eo);
      end
      @(posedge CLK);
      @(negedge CLK);
      out_ready = 1'b0;
   endtask

   task automatic test_random;
      int lat, stall;
      logic [W-1:0] ta, tb, r1, r2, er;
      logic ts, c1, o1, c2, o2, ec, eo;
      for (int k = 0; k < 3000; k++) begin
         ta = W'($urandom); tb = W'($urandom); ts = 1'($urandom_range(0, 1));
         if (k % 7 == 0) tb = ta;
         stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         ref_model(ta, tb, ts, er, ec, eo);
         run_op(ta, tb, ts, stall, lat, r1, c1, o1, r2, c2, o2);
         total++; if (lat != W + 1) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, lat, W + 1); end
         total++; if (r1 !== er || c1 !== ec || o1 !== eo) begin
            bad++; $display("FAIL rnd%0d_value a=%h b=%h sub=%b got=%h/%b/%b want=%h/%b/%b", k, ta, tb, ts, r1, c1, o1, er, ec, eo);
         end
         total++; if (r2 !== r1 || c2 !== c1 || o2 !== o1) begin
            bad++; $display("FAIL rnd%0d_stall_hold got=%h/%b/%b want=%h/%b/%b", k, r2, c2, o2, r1, c1, o1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
